// File: rtl/seq_ctrl_if.sv
// seq_ctrl_if: control handshake and datapath strobe bundle for seq_ctrl.
//   master side (controller user) drives start, abort, iters and observes
//   dp_rst, ld, en, busy, done, cnt.
//   slave side (seq_ctrl) consumes the requests and drives the strobes.
interface seq_ctrl_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] iters;
    logic             dp_rst;
    logic             ld;
    logic             en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;

    modport master (
        output start, abort, iters,
        input  dp_rst, ld, en, busy, done, cnt
    );

    modport slave (
        input  start, abort, iters,
        output dp_rst, ld, en, busy, done, cnt
    );
endinterface

// File: rtl/seq_ctrl.sv
// seq_ctrl: sequences a datapath through one clear cycle, one load cycle and
// a captured number of enable cycles, then a one-cycle done pulse.
// Runs can be aborted and, with AUTO_RESTART, relaunched straight from DONE.
//
// Ports:
//   clk  - rising-edge clock
//   clr  - synchronous active-high reset, overrides everything
//   bus  - seq_ctrl_if.slave:
//            start, abort, iters  (in)
//            dp_rst, ld, en, busy, done, cnt  (out)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; iters captured on acceptance
// CLEAR | one cycle of dp_rst; run counter cleared
// LOAD  | one cycle of ld; skips to DONE for a zero-length run
// RUN   | en high, counter increments; leaves after target cycles
// DONE  | one-cycle done pulse; may relaunch when AUTO_RESTART=1
module seq_ctrl #(
    parameter int CNT_W        = 8,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] w_target_m1;
    logic             w_capture;
    logic             w_last;

    logic w_dp_rst;
    logic w_ld;
    logic w_en;
    logic w_busy;
    logic w_done;

    // RUN is only entered with a non-zero target, so target-1 never wraps there.
    assign w_target_m1 = r_target - CNT_W'(1);
    assign w_last      = (r_cnt == w_target_m1);

    // iters is latched whenever a run is launched, from IDLE or from DONE.
    assign w_capture = bus.start &&
                       ((r_state == S_IDLE) ||
                        (AUTO_RESTART && (r_state == S_DONE)));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_target <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_target <= bus.iters;
            end
            if (r_state == S_CLEAR) begin
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                // Increments even on the aborting edge, so cnt reports issued en cycles.
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        w_dp_rst     = 1'b0;
        w_ld         = 1'b0;
        w_en         = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state = bus.start ? S_CLEAR : S_IDLE;
            end
            S_CLEAR: begin
                w_dp_rst     = 1'b1;
                w_busy       = 1'b1;
                w_next_state = bus.abort ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                w_ld   = 1'b1;
                w_busy = 1'b1;
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else if (r_target == '0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_en   = 1'b1;
                w_busy = 1'b1;
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (AUTO_RESTART && bus.start) begin
                    w_next_state = S_CLEAR;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                // Unused codes recover to IDLE.
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.dp_rst = w_dp_rst;
    assign bus.ld     = w_ld;
    assign bus.en     = w_en;
    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.cnt    = r_cnt;

endmodule
